// File: rtl/multi_sprite_engine.sv
// multi_sprite_engine: VGA-style timing generator with NUM_SPRITES scaled
// 1bpp sprites drawn over a background colour.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_we/addr/wdata     byte-wide register write port
//   rrggbb                pixel colour, registered
//   hsync, vsync          sync pulses, registered and aligned with rrggbb
//   next_vertical         combinational pulse on the last cycle of a line
//   next_frame            combinational pulse on the last cycle of a frame
//   collision             sticky sprite-overlap flag
//
// Register map: sprite i at 32*i: +0 x, +1 y, +2 colour, +3 ctrl[0]=enable,
// +4+2r / +5+2r bitmap row r low/high byte. 0xF0 background, 0xF1 clears
// collision. x/y/colour/ctrl are double-buffered and commit at frame end;
// bitmaps are written live.
//
// Optional feature macro: SPRITE_COLLISION_EN (collision detection). When it
// is undefined collision is tied low and 0xF1 writes have no effect.

module sprite_lane #(
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 12
) (
  input  logic [11:0]                    bh,
  input  logic [11:0]                    bv,
  input  logic [7:0]                     x,
  input  logic [7:0]                     y,
  input  logic                           en,
  input  logic [SPRITE_HEIGHT-1:0][15:0] rows,
  output logic                           hit
);
  // Coordinates are compared 12 bits wide so x+width never wraps back onto
  // the left/top edge of the screen.
  logic [11:0] x12, y12, dy;
  logic [3:0]  col;
  logic [15:0] row;
  logic        cov;

  assign x12 = {4'b0, x};
  assign y12 = {4'b0, y};
  assign dy  = bv - y12;
  assign col = 4'(bh - x12);
  assign cov = (bh >= x12) && (bh < x12 + 12'(SPRITE_WIDTH)) &&
               (bv >= y12) && (bv < y12 + 12'(SPRITE_HEIGHT));

  always_comb begin
    row = '0;
    for (int r = 0; r < SPRITE_HEIGHT; r++)
      if (dy == 12'(r)) row = rows[r];
  end

  assign hit = en && cov && row[col];
endmodule

module multi_sprite_engine #(
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 12,
  parameter int SCALE_LOG2    = 3,
  parameter int WIDTH  = 800, parameter int HFRONT = 40,
  parameter int HSYNC  = 128, parameter int HBACK  = 88,
  parameter int HEIGHT = 600, parameter int VFRONT = 1,
  parameter int VSYNC  = 4,   parameter int VBACK  = 23
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [5:0] rrggbb,
  output logic       hsync,
  output logic       vsync,
  output logic       next_vertical,
  output logic       next_frame,
  output logic       collision
);
  localparam int HTOTAL = WIDTH + HFRONT + HSYNC + HBACK;
  localparam int VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int NS = NUM_SPRITES;

  // ---------------- timing ----------------
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (next_vertical) begin
      h <= '0;
      v <= (v == VW'(VTOTAL-1)) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign next_vertical = (h == HW'(HTOTAL-1));
  assign next_frame    = next_vertical && (v == VW'(VTOTAL-1));

  // ---------------- configuration ----------------
  logic [NS-1:0][7:0] sh_x, sh_y, ac_x, ac_y;
  logic [NS-1:0][5:0] sh_col, ac_col;
  logic [NS-1:0]      sh_en, ac_en;
  logic [NS-1:0][SPRITE_HEIGHT-1:0][15:0] bmp;
  logic [5:0]         bg;
  logic               spr_wr;
  logic [2:0]         idx;
  logic [4:0]         off;

  // 0xF0..0xFF belong to the global block even if sprite 7 exists.
  // Bitmap rows whose offset would exceed +31 alias the next sprite's
  // register window and are not writable.
  assign spr_wr = cfg_we && (cfg_addr < 8'hF0);
  assign idx    = cfg_addr[7:5];
  assign off    = cfg_addr[4:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) begin
        sh_x[i]   <= 8'(16*i);  ac_x[i]   <= 8'(16*i);
        sh_y[i]   <= 8'd8;      ac_y[i]   <= 8'd8;
        sh_col[i] <= 6'b110001; ac_col[i] <= 6'b110001;
        sh_en[i]  <= (i == 0);  ac_en[i]  <= (i == 0);
      end
      bmp <= '0;
      bg  <= 6'b010101;
    end else begin
      // Commit reads the shadow before any same-cycle write lands.
      if (next_frame) begin
        ac_x   <= sh_x;
        ac_y   <= sh_y;
        ac_col <= sh_col;
        ac_en  <= sh_en;
      end
      if (cfg_we && cfg_addr == 8'hF0) bg <= cfg_wdata[5:0];
      for (int i = 0; i < NS; i++) begin
        if (spr_wr && idx == 3'(i)) begin
          case (off)
            5'd0:    sh_x[i]   <= cfg_wdata;
            5'd1:    sh_y[i]   <= cfg_wdata;
            5'd2:    sh_col[i] <= cfg_wdata[5:0];
            5'd3:    sh_en[i]  <= cfg_wdata[0];
            default: ;
          endcase
          for (int r = 0; r < SPRITE_HEIGHT; r++) begin
            if (int'(off) == 4 + 2*r) bmp[i][r][7:0]  <= cfg_wdata;
            if (int'(off) == 5 + 2*r) bmp[i][r][15:8] <= cfg_wdata;
          end
        end
      end
    end
  end

  // ---------------- sprite lanes ----------------
  logic [11:0]   bh, bv;
  logic [NS-1:0] hits;
  logic          visible;
  logic [5:0]    pix;

  assign bh      = 12'(h >> SCALE_LOG2);
  assign bv      = 12'(v >> SCALE_LOG2);
  assign visible = (int'(h) < WIDTH) && (int'(v) < HEIGHT);

  for (genvar i = 0; i < NS; i++) begin : g_lane
    sprite_lane #(.SPRITE_WIDTH(SPRITE_WIDTH), .SPRITE_HEIGHT(SPRITE_HEIGHT)) u_lane (
      .bh(bh), .bv(bv), .x(ac_x[i]), .y(ac_y[i]), .en(ac_en[i]),
      .rows(bmp[i]), .hit(hits[i])
    );
  end

  // Walk from the top index down so the lowest hitting index wins.
  always_comb begin
    pix = bg;
    for (int i = NS-1; i >= 0; i--)
      if (hits[i]) pix = ac_col[i];
    if (!visible) pix = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrggbb <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else begin
      rrggbb <= pix;
      hsync  <= (int'(h) >= WIDTH + HFRONT) && (int'(h) < WIDTH + HFRONT + HSYNC);
      vsync  <= (int'(v) >= HEIGHT + VFRONT) && (int'(v) < HEIGHT + VFRONT + VSYNC);
    end
  end

`ifdef SPRITE_COLLISION_EN
  // Two or more hits: clear the lowest set bit and see if anything remains.
  logic multi;
  assign multi = visible && ((hits & (hits - NS'(1))) != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            collision <= 1'b0;
    else if (multi)                          collision <= 1'b1;
    else if (cfg_we && cfg_addr == 8'hF1)    collision <= 1'b0;
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_multi_sprite_engine.sv
// tb_multi_sprite_engine: drives register writes (directed and $urandom)
// against a reduced screen geometry and compares every output, every cycle,
// with a behavioural model of the sprite engine kept in this file.
module tb_multi_sprite_engine;
  localparam int NS = 4, SW = 12, SH = 12, S = 2;
  localparam int WIDTH = 64, HFRONT = 4, HSYNC = 8, HBACK = 4;
  localparam int HEIGHT = 48, VFRONT = 1, VSYNC = 2, VBACK = 3;
  localparam int HT = WIDTH + HFRONT + HSYNC + HBACK;   // 80
  localparam int VT = HEIGHT + VFRONT + VSYNC + VBACK;  // 54
  localparam int FRAME = HT * VT;
  localparam int CAP_V = 20;
  localparam logic [5:0] C0 = 6'b110001, BG = 6'b010101, C1 = 6'h0A;

  logic       clk = 1'b0, reset_n = 1'b1, cfg_we = 1'b0;
  logic [7:0] cfg_addr = '0, cfg_wdata = '0;
  logic [5:0] rrggbb;
  logic       hsync, vsync, next_vertical, next_frame, collision;

  multi_sprite_engine #(
    .NUM_SPRITES(NS), .SPRITE_WIDTH(SW), .SPRITE_HEIGHT(SH), .SCALE_LOG2(S),
    .WIDTH(WIDTH), .HFRONT(HFRONT), .HSYNC(HSYNC), .HBACK(HBACK),
    .HEIGHT(HEIGHT), .VFRONT(VFRONT), .VSYNC(VSYNC), .VBACK(VBACK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .rrggbb(rrggbb), .hsync(hsync), .vsync(vsync),
    .next_vertical(next_vertical), .next_frame(next_frame), .collision(collision)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int k;                       // clock edges since reset release
  logic have_exp;
  logic [5:0] e_pix;
  logic e_hs, e_vs, e_col;
  int ph, pv;
  logic [5:0] line [HT];

  // model state
  int m_sx[NS], m_sy[NS], m_ax[NS], m_ay[NS];
  logic [5:0] m_sc[NS], m_ac[NS], m_bg;
  bit m_se[NS], m_ae[NS];
  logic [15:0] m_bm[NS][SH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_sx[i] = 16*i; m_sy[i] = 8; m_sc[i] = C0; m_se[i] = (i == 0);
      for (int r = 0; r < SH; r++) m_bm[i][r] = '0;
    end
    m_ax = m_sx; m_ay = m_sy; m_ac = m_sc; m_ae = m_se;
    m_bg = BG;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    int i, off;
    if (a == 'hF0) m_bg = d[5:0];
    else if (a < 'hF0) begin
      i = a / 32; off = a % 32;
      if (i < NS) begin
        if (off == 0) m_sx[i] = int'(d);
        else if (off == 1) m_sy[i] = int'(d);
        else if (off == 2) m_sc[i] = d[5:0];
        else if (off == 3) m_se[i] = d[0];
        else if (off < 4 + 2*SH) begin
          if (off % 2 == 0) m_bm[i][(off-4)/2][7:0]  = d;
          else              m_bm[i][(off-4)/2][15:8] = d;
        end
      end
    end
  endfunction

  // Colour of screen pixel (h,v) and how many sprites cover it with a set bit.
  function automatic logic [5:0] model_pix(input int h, input int v, output int nh);
    int bh, bv;
    logic [5:0] p;
    bit found;
    bh = h >> S; bv = v >> S; nh = 0; p = m_bg; found = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_ae[i] && bh >= m_ax[i] && bh < m_ax[i] + SW &&
          bv >= m_ay[i] && bv < m_ay[i] + SH &&
          m_bm[i][bv - m_ay[i]][bh - m_ax[i]]) begin
        nh++;
        if (!found) begin p = m_ac[i]; found = 1; end
      end
    end
    if (h >= WIDTH || v >= HEIGHT) p = '0;
    return p;
  endfunction

  // One clock: check outputs for the previous state, predict this state,
  // drive an optional write, advance to the next negedge.
  task automatic step(input logic we, input logic [7:0] a, input logic [7:0] d);
    int h, v, nh;
    h = k % HT; v = (k / HT) % VT;
    if (have_exp) begin
      chk("rgb", 32'(rrggbb), 32'(e_pix));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("collision", 32'(collision), 32'(e_col));
      if (pv == CAP_V) line[ph] = rrggbb;
    end
    chk("next_vertical", 32'(next_vertical), 32'(h == HT-1));
    chk("next_frame", 32'(next_frame), 32'(h == HT-1 && v == VT-1));
    e_pix = model_pix(h, v, nh);
    e_hs = (h >= WIDTH + HFRONT) && (h < WIDTH + HFRONT + HSYNC);
    e_vs = (v >= HEIGHT + VFRONT) && (v < HEIGHT + VFRONT + VSYNC);
`ifdef SPRITE_COLLISION_EN
    if (h < WIDTH && v < HEIGHT && nh >= 2) e_col = 1'b1;
    else if (we && a == 8'hF1) e_col = 1'b0;
`endif
    if (h == HT-1 && v == VT-1) begin
      m_ax = m_sx; m_ay = m_sy; m_ac = m_sc; m_ae = m_se;
    end
    if (we) model_write(int'(a), d);
    cfg_we = we; cfg_addr = a; cfg_wdata = d;
    have_exp = 1'b1; ph = h; pv = v;
    @(negedge clk);
    k++;
  endtask

  task automatic wr(input int a, input int d);
    step(1'b1, 8'(a), 8'(d));
  endtask

  task automatic run_to(input int th, input int tv);
    while (k % FRAME != tv*HT + th) step(1'b0, 8'h00, 8'h00);
  endtask

  task automatic chk_line(input string tag, input int h0, input int h1, input logic [5:0] e);
    for (int h = h0; h <= h1; h++) chk(tag, 32'(line[h]), 32'(e));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    k = 0; have_exp = 1'b0; e_col = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_rgb", 32'(rrggbb), 0);
    chk("rst_hsync", 32'(hsync), 0);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_nvert", 32'(next_vertical), 0);
    chk("rst_nframe", 32'(next_frame), 0);
    chk("rst_coll", 32'(collision), 0);
  endtask

  initial begin
    int cls, i;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    release_reset();

    // one idle frame: timing and background only
    step(1'b0, 8'h00, 8'h00);
    run_to(0, 0);

    // sprite 0 at (10,5), single pixel in row 0
    wr(0, 10); wr(1, 5); wr(4, 8'h01); wr(5, 8'h00);
    run_to(0, 0);
    run_to(2, CAP_V + 1);
    chk_line("dot_on", 40, 43, C0);
    chk("dot_left", 32'(line[39]), 32'(BG));
    chk("dot_right", 32'(line[44]), 32'(BG));

    // mid-frame move is deferred; a frame-end write waits one more frame
    run_to(0, 0);
    run_to(0, 10);
    wr(0, 12);
    run_to(2, CAP_V + 1);
    chk_line("defer_old", 40, 43, C0);
    chk("defer_new", 32'(line[48]), 32'(BG));
    run_to(HT-1, VT-1);
    wr(0, 14);
    run_to(2, CAP_V + 1);
    chk_line("moved", 48, 51, C0);

    // overlap of sprites 0 and 1: sprite 0 wins
    wr(0, 12);
    wr(32, 12); wr(33, 5); wr(34, C1); wr(35, 1); wr(36, 8'h03);
    run_to(0, 0);
    run_to(2, CAP_V + 1);
    chk_line("ovl_s0", 48, 51, C0);
    chk_line("ovl_s1", 52, 55, C1);
    chk("ovl_bg", 32'(line[56]), 32'(BG));
`ifdef SPRITE_COLLISION_EN
    chk("coll_set", 32'(collision), 1);
`else
    chk("coll_set", 32'(collision), 0);
`endif
    run_to(0, 50);
    wr('hF1, 0);
    chk("coll_clr", 32'(collision), 0);

    // right-edge clip: sprite 0 at bh 13, all bits set, sprite 1 off
    wr(0, 13); wr(35, 0);
    for (int r = 0; r < SH; r++) begin wr(4 + 2*r, 'hFF); wr(5 + 2*r, 'hFF); end
    run_to(0, 0);
    run_to(2, CAP_V + 1);
    chk_line("clip_in", 52, 63, C0);
    chk_line("clip_nowrap", 0, 27, BG);
    chk_line("clip_blank", 64, HT-1, 6'd0);

    // random register traffic over two frames
    for (int n = 0; n < 2*FRAME; n++) begin
      if ($urandom_range(0, 7) != 0) step(1'b0, 8'h00, 8'h00);
      else begin
        cls = $urandom_range(0, 4);
        i = $urandom_range(0, NS-1);
        case (cls)
          0: begin
            int o;
            o = $urandom_range(0, 3);
            wr(32*i + o, (o == 0) ? $urandom_range(0, 18) :
                         (o == 1) ? $urandom_range(0, 13) : $urandom_range(0, 255));
          end
          1: wr(32*i + $urandom_range(4, 31), $urandom_range(0, 255));
          2: wr('hF0, $urandom_range(0, 63));
          3: wr('hF1, $urandom_range(0, 255));
          default: wr($urandom_range(0, 255), $urandom_range(0, 255));
        endcase
      end
    end

    // asynchronous reset mid-frame, then a clean frame from h=0,v=0
    run_to(30, 20);
    cfg_we = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    release_reset();
    step(1'b0, 8'h00, 8'h00);
    run_to(0, 0);
    step(1'b0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
